// File: rtl/core_mem_arbiter.sv
// Shares one single-beat memory port between instruction fetch (I) and load/store (D),
// one transaction in flight, with a watchdog abort. Define MEMARB_RR_EN for round-robin ties.
module core_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                I_REQ,
  input  logic [ADDR_W-1:0]   I_ADDR,
  output logic                I_ACK,
  input  logic                D_REQ,
  input  logic                D_WE,
  input  logic [ADDR_W-1:0]   D_ADDR,
  input  logic [DATA_W-1:0]   D_WDATA,
  input  logic [DATA_W/8-1:0] D_STRB,
  output logic                D_ACK,
  output logic [DATA_W-1:0]   RDATA,
  output logic                M_REQ,
  output logic                M_WE,
  output logic [ADDR_W-1:0]   M_ADDR,
  output logic [DATA_W-1:0]   M_WDATA,
  output logic [DATA_W/8-1:0] M_STRB,
  input  logic                M_ACK,
  input  logic [DATA_W-1:0]   M_RDATA,
  output logic                BUSY,
  output logic                ERR
);

  localparam int              WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit              WD_EN   = (TIMEOUT_CYC > 0);

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D,
    DONE
  } state_t;

  state_t          state;
  logic [WD_W-1:0] wdog;
  logic            pick_d;
  logic            in_grant;
  logic            timeout_hit;
  logic            done_now;

`ifdef MEMARB_RR_EN
  // rr_d = 1: D wins the next simultaneous request; flips away from whoever was just served
  logic rr_d;

  always_comb pick_d = D_REQ && (!I_REQ || rr_d);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rr_d <= 1'b0;
    end else if (done_now) begin
      rr_d <= (state == GNT_I);
    end
  end
`else
  always_comb pick_d = D_REQ;
`endif

  always_comb begin
    in_grant    = (state == GNT_I) || (state == GNT_D);
    timeout_hit = WD_EN && (wdog == WD_LAST);
    done_now    = in_grant && (M_ACK || timeout_hit);
  end

  // NOTE: every register here is assigned with <= so all outputs change together at the
  // edge and no branch can observe a half-updated value from the same cycle.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state   <= IDLE;
      wdog    <= '0;
      M_REQ   <= 1'b0;
      M_WE    <= 1'b0;
      M_ADDR  <= '0;
      M_WDATA <= '0;
      M_STRB  <= '0;
      RDATA   <= '0;
      I_ACK   <= 1'b0;
      D_ACK   <= 1'b0;
      ERR     <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      I_ACK <= 1'b0;
      D_ACK <= 1'b0;
      ERR   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (I_REQ || D_REQ) begin
            state   <= pick_d ? GNT_D : GNT_I;
            wdog    <= '0;
            M_REQ   <= 1'b1;
            BUSY    <= 1'b1;
            M_WE    <= pick_d && D_WE;
            M_ADDR  <= pick_d ? D_ADDR : I_ADDR;
            M_WDATA <= pick_d ? D_WDATA : '0;
            M_STRB  <= (pick_d && D_WE) ? D_STRB : '0;
          end
        end
        GNT_I, GNT_D: begin
          if (done_now) begin
            // a response on the final watchdog cycle still counts as a normal completion
            state <= DONE;
            M_REQ <= 1'b0;
            RDATA <= M_ACK ? M_RDATA : '0;
            ERR   <= !M_ACK;
            I_ACK <= (state == GNT_I);
            D_ACK <= (state == GNT_D);
          end else if (WD_EN) begin
            wdog <= wdog + 1'b1;
          end
        end
        DONE: begin
          // holdoff: a requester still showing REQ during its ACK cycle is not re-granted
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          M_REQ <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: reset, directed vectors, corner sequences and
// randomized I/D traffic against a transaction-level model. Follows MEMARB_RR_EN if defined.
module tb_core_mem_arbiter;

  localparam int TO = 8;
`ifdef MEMARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        I_REQ = 1'b0;
  logic [31:0] I_ADDR = '0;
  logic        I_ACK;
  logic        D_REQ = 1'b0;
  logic        D_WE = 1'b0;
  logic [31:0] D_ADDR = '0;
  logic [31:0] D_WDATA = '0;
  logic [3:0]  D_STRB = '0;
  logic        D_ACK;
  logic [31:0] RDATA;
  logic        M_REQ;
  logic        M_WE;
  logic [31:0] M_ADDR;
  logic [31:0] M_WDATA;
  logic [3:0]  M_STRB;
  logic        M_ACK = 1'b0;
  logic [31:0] M_RDATA = '0;
  logic        BUSY;
  logic        ERR;

  core_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_ACK(I_ACK),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_STRB(D_STRB),
    .D_ACK(D_ACK), .RDATA(RDATA),
    .M_REQ(M_REQ), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_STRB(M_STRB),
    .M_ACK(M_ACK), .M_RDATA(M_RDATA),
    .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } txn_t;

  typedef struct {
    bit          side;       // 1 = D, 0 = I
    txn_t        t;
    int          lat;        // cycles after M_REQ rises before memory answers
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int unsigned cyc;
  } mreq_ev_t;

  typedef struct {
    logic [1:0]  acks;       // {I_ACK, D_ACK}
    bit          err;
    logic [31:0] rdata;
    int unsigned cyc;
  } ack_ev_t;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  mreq_ev_t mreq_q[$];
  ack_ev_t  ack_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  int resp_lat = 0;
  bit resp_never = 1'b0;
  bit late_ack = 1'b0;
  int age = 0;
  int last_len = 0;
  int unstable = 0;
  logic [100:0] hold;
  bit ptr_d = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // memory responder: answers resp_lat cycles after M_REQ rises, logs each request
  always @(negedge CLK) begin
    logic [31:0] cur;
    M_ACK = 1'b0;
    M_RDATA = '0;
    if (M_REQ) begin
      if (age == 0) begin
        mreq_q.push_back('{M_WE, M_ADDR, M_WDATA, M_STRB, cyc});
        hold = {M_WE, M_ADDR, M_WDATA, M_STRB};
      end else if ({M_WE, M_ADDR, M_WDATA, M_STRB} !== hold) begin
        unstable++;
      end
      if (!resp_never && age == resp_lat) begin
        cur = mem.exists(M_ADDR) ? mem[M_ADDR] : 32'h0;
        M_ACK = 1'b1;
        if (M_WE) mem[M_ADDR] = merge(cur, M_WDATA, M_STRB);
        else      M_RDATA = cur;
      end
      age++;
    end else begin
      if (age > 0) last_len = age;
      age = 0;
      if (late_ack) begin
        M_ACK = 1'b1;
        M_RDATA = 32'hFFFF_FFFF;
      end
    end
  end

  always @(negedge CLK) begin
    if (I_ACK || D_ACK || ERR) ack_q.push_back('{{I_ACK, D_ACK}, ERR, RDATA, cyc});
  end

  // raise the chosen requests together; each is dropped one cycle after its ACK is seen
  task automatic issue(input bit use_i, input bit use_d, input txn_t ti, input txn_t td,
                       input int budget, output int unsigned raise_cyc);
    bit pend_i, pend_d, drop_i, drop_d;
    @(negedge CLK);
    raise_cyc = cyc;
    if (use_i) begin
      I_REQ = 1'b1; I_ADDR = ti.addr;
    end
    if (use_d) begin
      D_REQ = 1'b1; D_WE = td.we; D_ADDR = td.addr; D_WDATA = td.wdata; D_STRB = td.strb;
    end
    pend_i = use_i; pend_d = use_d; drop_i = 1'b0; drop_d = 1'b0;
    for (int n = 0; n < budget && (pend_i || pend_d || drop_i || drop_d); n++) begin
      @(negedge CLK);
      if (drop_i) begin I_REQ = 1'b0; drop_i = 1'b0; end
      if (drop_d) begin D_REQ = 1'b0; drop_d = 1'b0; end
      if (pend_i && I_ACK) begin pend_i = 1'b0; drop_i = 1'b1; end
      if (pend_d && D_ACK) begin pend_d = 1'b0; drop_d = 1'b1; end
    end
    if (pend_i || pend_d || drop_i || drop_d) begin
      check("ack_timeout", {pend_i, pend_d}, 2'b00);
      I_REQ = 1'b0;
      D_REQ = 1'b0;
    end
  endtask

  task automatic expect_grant(input string tag, input bit side, input txn_t t,
                              input logic [31:0] exp_rdata, input int lat, input bit tmo,
                              input int unsigned exp_mcyc, output int unsigned ack_cyc);
    mreq_ev_t m;
    ack_ev_t  a;
    bit       wr;
    ack_cyc = 0;
    wr = side && t.we;
    if (mreq_q.size() == 0) begin
      check({tag, "_mreq_missing"}, 0, 1);
      return;
    end
    m = mreq_q.pop_front();
    check({tag, "_mreq_cycle"}, m.cyc, exp_mcyc);
    check({tag, "_maddr"}, m.addr, t.addr);
    check({tag, "_mwe"}, m.we, wr);
    check({tag, "_mstrb"}, m.strb, wr ? t.strb : 4'h0);
    if (wr) check({tag, "_mwdata"}, m.wdata, t.wdata);
    if (ack_q.size() == 0) begin
      check({tag, "_ack_missing"}, 0, 1);
      return;
    end
    a = ack_q.pop_front();
    ack_cyc = a.cyc;
    check({tag, "_ack_side"}, a.acks, side ? 2'b01 : 2'b10);
    check({tag, "_err"}, a.err, tmo);
    check({tag, "_ack_latency"}, a.cyc - m.cyc, tmo ? TO : lat + 1);
    if (tmo)     check({tag, "_rdata_abort"}, a.rdata, 32'h0);
    else if (!wr) check({tag, "_rdata"}, a.rdata, exp_rdata);
  endtask

  task automatic do_reset();
    I_REQ = 1'b0; D_REQ = 1'b0; late_ack = 1'b0; resp_never = 1'b0;
    @(negedge CLK);
    RSTN = 1'b0;
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    #1;
    ack_q.delete();
    mreq_q.delete();
    ptr_d = 1'b0;
  endtask

  function automatic txn_t mkt(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [3:0] st);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wd; t.strb = st;
    return t;
  endfunction

  function automatic vec_t mkv(input bit side, input txn_t t, input int lat,
                               input logic [31:0] er);
    vec_t v;
    v.side = side; v.t = t; v.lat = lat; v.exp_rdata = er;
    return v;
  endfunction

  task automatic run_pair(input string tag, input txn_t ti, input txn_t td, input int lat,
                          input bit first_d, input logic [31:0] exp_ri,
                          input logic [31:0] exp_rd);
    int unsigned rc, a1, a2;
    resp_lat = lat;
    issue(1'b1, 1'b1, ti, td, 60, rc);
    #1;
    if (first_d) begin
      expect_grant({tag, "_d"}, 1'b1, td, exp_rd, lat, 1'b0, rc + 1, a1);
      expect_grant({tag, "_i"}, 1'b0, ti, exp_ri, lat, 1'b0, a1 + 2, a2);
    end else begin
      expect_grant({tag, "_i"}, 1'b0, ti, exp_ri, lat, 1'b0, rc + 1, a1);
      expect_grant({tag, "_d"}, 1'b1, td, exp_rd, lat, 1'b0, a1 + 2, a2);
    end
    check({tag, "_ack_gap"}, a2 - a1, lat + 3);
  endtask

  task automatic run_random(input int iters);
    txn_t ti, td, t;
    int kind, lat, n;
    bit order [2];
    logic [31:0] er [2];
    logic [31:0] cur;
    bit first_d;
    int unsigned rc, a1, a2;
    for (int it = 0; it < iters; it++) begin
      kind = $urandom_range(0, 2);
      lat  = $urandom_range(0, 6);
      ti = mkt(1'b0, 32'h400 + 32'($urandom_range(0, 3)) * 4, 32'h0, 4'h0);
      td = mkt(1'($urandom_range(0, 1)), 32'h400 + 32'($urandom_range(0, 3)) * 4,
               $urandom, 4'($urandom_range(1, 15)));
      if (kind == 0) begin
        n = 1; order[0] = 1'b0; order[1] = 1'b0;
      end else if (kind == 1) begin
        n = 1; order[0] = 1'b1; order[1] = 1'b0;
      end else begin
        n = 2;
        first_d = RR ? ptr_d : 1'b1;
        order[0] = first_d; order[1] = !first_d;
      end
      for (int k = 0; k < n; k++) begin
        t = order[k] ? td : ti;
        cur = ref_mem.exists(t.addr) ? ref_mem[t.addr] : 32'h0;
        if (order[k] && t.we) ref_mem[t.addr] = merge(cur, t.wdata, t.strb);
        er[k] = cur;
        ptr_d = !order[k];
      end
      resp_lat = lat;
      issue(kind != 1, kind != 0, ti, td, 60, rc);
      #1;
      expect_grant($sformatf("rnd%0d_a", it), order[0], order[0] ? td : ti, er[0], lat,
                   1'b0, rc + 1, a1);
      if (n == 2)
        expect_grant($sformatf("rnd%0d_b", it), order[1], order[1] ? td : ti, er[1], lat,
                     1'b0, a1 + 2, a2);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vec_t vecs [7];
    int unsigned rc, a1;

    mem[32'h100] = 32'h0000_0013;
    mem[32'h104] = 32'hDEAD_BEEF;
    mem[32'h200] = 32'h1122_3344;
    mem[32'h300] = 32'h0BAD_F00D;

    vecs[0] = mkv(1'b0, mkt(1'b0, 32'h100, 32'h0, 4'h0), 1, 32'h0000_0013);
    vecs[1] = mkv(1'b1, mkt(1'b1, 32'h200, 32'hCAFE_BABE, 4'b0011), 0, 32'h0);
    vecs[2] = mkv(1'b1, mkt(1'b0, 32'h200, 32'h5555_5555, 4'hF), 2, 32'h1122_BABE);
    vecs[3] = mkv(1'b0, mkt(1'b0, 32'h104, 32'h0, 4'h0), 5, 32'hDEAD_BEEF);
    vecs[4] = mkv(1'b1, mkt(1'b1, 32'h104, 32'hA5A5_0000, 4'b1100), 3, 32'h0);
    vecs[5] = mkv(1'b0, mkt(1'b0, 32'h104, 32'h0, 4'h0), 0, 32'hA5A5_BEEF);
    vecs[6] = mkv(1'b1, mkt(1'b0, 32'h300, 32'h0, 4'h0), TO - 1, 32'h0BAD_F00D);

    repeat (2) @(negedge CLK);
    check("rst_mreq", M_REQ, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_ack_err", {I_ACK, D_ACK, ERR}, 3'b000);
    check("rst_rdata", RDATA, 32'h0);
    check("rst_mfields", {M_WE, M_ADDR, M_WDATA, M_STRB}, 0);
    RSTN = 1'b1;
    @(negedge CLK);
    check("rst_release_busy", BUSY, 1'b0);

    for (int p = 0; p < 4; p++)
      run_pair($sformatf("pair%0d", p), mkt(1'b0, 32'h100, 32'h0, 4'h0),
               mkt(1'b0, 32'h200, 32'h0, 4'h0), p, RR ? 1'b0 : 1'b1,
               32'h0000_0013, 32'h1122_3344);

    for (int i = 0; i < 7; i++) begin
      resp_lat = vecs[i].lat;
      issue(!vecs[i].side, vecs[i].side, vecs[i].t, vecs[i].t, 60, rc);
      #1;
      expect_grant($sformatf("vec%0d", i), vecs[i].side, vecs[i].t, vecs[i].exp_rdata,
                   vecs[i].lat, 1'b0, rc + 1, a1);
      check($sformatf("vec%0d_mreq_len", i), last_len, vecs[i].lat + 1);
      check($sformatf("vec%0d_busy_after1", i), BUSY, 1'b0);
      @(negedge CLK);
      check($sformatf("vec%0d_busy_after2", i), BUSY, 1'b0);
    end

    // watchdog abort, with memory acking late in every cycle M_REQ is low
    resp_never = 1'b1;
    late_ack = 1'b1;
    issue(1'b0, 1'b1, mkt(1'b0, 32'h0, 32'h0, 4'h0), mkt(1'b0, 32'h300, 32'h0, 4'hF), 60, rc);
    #1;
    expect_grant("timeout", 1'b1, mkt(1'b0, 32'h300, 32'h0, 4'hF), 32'h0, 0, 1'b1, rc + 1, a1);
    check("timeout_mreq_len", last_len, TO);
    repeat (3) @(negedge CLK);
    late_ack = 1'b0;
    resp_never = 1'b0;
    #1;
    check("late_ack_ignored", ack_q.size() + mreq_q.size(), 0);
    check("late_ack_busy", BUSY, 1'b0);

    // reset while D is granted and memory is silent
    resp_never = 1'b1;
    @(negedge CLK);
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 32'h500; D_WDATA = 32'h1234_5678; D_STRB = 4'hF;
    repeat (3) @(negedge CLK);
    check("rstmid_pre_mreq", M_REQ, 1'b1);
    check("rstmid_pre_busy", BUSY, 1'b1);
    #2 RSTN = 1'b0;
    #1;
    check("rstmid_mreq", M_REQ, 1'b0);
    check("rstmid_busy", BUSY, 1'b0);
    @(negedge CLK);
    D_REQ = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    resp_never = 1'b0;
    @(negedge CLK);
    #1;
    check("rstmid_no_ack", ack_q.size(), 0);
    check("rstmid_no_write", mem.exists(32'h500), 1'b0);
    mreq_q.delete();
    resp_lat = 1;
    issue(1'b1, 1'b0, mkt(1'b0, 32'h104, 32'h0, 4'h0), mkt(1'b0, 32'h0, 32'h0, 4'h0), 60, rc);
    #1;
    expect_grant("rstmid_fresh", 1'b0, mkt(1'b0, 32'h104, 32'h0, 4'h0), 32'hA5A5_BEEF, 1,
                 1'b0, rc + 1, a1);

    do_reset();
    run_random(40);

    repeat (2) @(negedge CLK);
    check("mreq_stable", unstable, 0);
    check("no_stray_events", ack_q.size() + mreq_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
